// File: rtl/mole_datapath.sv
// mole_datapath: key sync, game timer, mole handshake and scoring for the whack-a-mole FSM; MOLE_SPEEDUP_EN shrinks the mole window every 4th hit
module mole_datapath #(
  parameter int TICK_DIV = 50000000,
  parameter int GAME_SECONDS = 60,
  parameter int MOLE_CYCLES = 50000000,
  parameter int GAP_CYCLES = 25000000
`ifdef MOLE_SPEEDUP_EN
  , parameter int MOLE_MIN_CYCLES = 12500000
`endif
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] state,
  input  logic       game_start,
  input  logic [3:0] key,
  output logic       control_signal,
  output logic       timer_signal,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic [6:0] time_left
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(MOLE_CYCLES + 1);
  logic [3:0] sync1_q, sync2_q, prev_q, press;
  logic [2:0] st, saved_q, saved_d;
  logic [1:0] idx;
  logic start, in_game, in_mole, en, hit, wrong, expire, req, wrap, miss_ev;
  logic armed_q, armed_d, pulse_d, ctrl_q, timer_q, timer_d;
  logic [7:0] score_q, score_d, miss_q, miss_d;
  logic [6:0] time_q, time_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [WW-1:0] win_q, win_d, window;
`ifdef MOLE_SPEEDUP_EN
  logic [WW-1:0] window_q, window_d, shrunk;
  logic [1:0] hits_q, hits_d;
  // every 4th hit trims an eighth off the window, never below the floor; Start restores it
  always_comb begin
    shrunk = window_q - (window_q >> 3);
    hits_d = start ? 2'd0 : hit ? hits_q + 2'd1 : hits_q;
    window_d = start ? WW'(MOLE_CYCLES) :
               (hit && hits_q == 2'd3) ? ((shrunk < WW'(MOLE_MIN_CYCLES)) ? WW'(MOLE_MIN_CYCLES) : shrunk) :
               window_q;
  end
  // window length and hit-count state
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      window_q <= WW'(MOLE_CYCLES);
      hits_q <= 2'd0;
    end else begin
      window_q <= window_d;
      hits_q <= hits_d;
    end
  assign window = window_q;
`else
  assign window = WW'(MOLE_CYCLES);
`endif
  // decode state, detect events and compute every next-state value
  always_comb begin
    st = (state > 4'd6) ? 3'd0 : state[2:0];
    start = (st == 3'd0) | game_start;
    in_game = st == 3'd1;
    in_mole = (st >= 3'd2) & (st <= 3'd5);
    idx = 2'(st - 3'd2);
    press = sync2_q & ~prev_q;
    en = armed_q & ~start;
    hit = en & in_mole & press[idx];
    wrong = en & in_mole & (|(press & ~(4'b0001 << idx)));
    expire = en & in_mole & (win_q == window - WW'(1));
    req = en & in_game & ~timer_q & (gap_q == GW'(GAP_CYCLES - 1));
    wrap = ~start & (in_game | in_mole) & ~timer_q & (tick_q == TW'(TICK_DIV - 1));
    miss_ev = ~hit & (expire | wrong);
    pulse_d = hit | expire | req;
    tick_d = (start | wrap) ? '0 : ((in_game | in_mole) & ~timer_q) ? tick_q + TW'(1) : tick_q;
    time_d = start ? 7'(GAME_SECONDS) : (wrap && time_q != 7'd0) ? time_q - 7'd1 : time_q;
    timer_d = ~start & (timer_q | (wrap & (time_q == 7'd1)));
    gap_d = (en & in_game & (gap_q != GW'(GAP_CYCLES - 1))) ? gap_q + GW'(1) : '0;
    win_d = (en & in_mole & ~pulse_d) ? win_q + WW'(1) : '0;
    score_d = start ? 8'd0 : (hit && score_q != 8'hff) ? score_q + 8'd1 : score_q;
    miss_d = start ? 8'd0 : (miss_ev && miss_q != 8'hff) ? miss_q + 8'd1 : miss_q;
    armed_d = start | (~pulse_d & (armed_q | (st != saved_q)));
    saved_d = pulse_d ? st : saved_q;
  end
  // synchronizers, counters, handshake and score registers
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      prev_q <= 4'd0;
      tick_q <= '0;
      gap_q <= '0;
      win_q <= '0;
      time_q <= 7'(GAME_SECONDS);
      timer_q <= 1'b0;
      score_q <= 8'd0;
      miss_q <= 8'd0;
      armed_q <= 1'b1;
      saved_q <= 3'd0;
      ctrl_q <= 1'b0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      tick_q <= tick_d;
      gap_q <= gap_d;
      win_q <= win_d;
      time_q <= time_d;
      timer_q <= timer_d;
      score_q <= score_d;
      miss_q <= miss_d;
      armed_q <= armed_d;
      saved_q <= saved_d;
      ctrl_q <= pulse_d;
    end
  assign control_signal = ctrl_q;
  assign timer_signal = timer_q;
  assign score = score_q;
  assign misses = miss_q;
  assign time_left = time_q;
endmodule

// File: doc/mole_datapath.md
Name: mole_datapath

Overview:
- Datapath partner to the game-control FSM.
- Consumes the FSM's registered state code, game_start and the four player hit buttons.
- Produces control_signal pulses (mole request, hit or mole timeout) and the level timer_signal (game time expired) that drive the FSM's transitions.
- Also keeps the score, miss count and seconds remaining for the VGA/HEX display.

Parameters:
- TICK_DIV, 50000000, clk cycles per game second.
- GAME_SECONDS, 60, game length in seconds (1..127).
- MOLE_CYCLES, 50000000, clk cycles a mole stays up before counting as a miss.
- GAP_CYCLES, 25000000, clk cycles spent in Game before requesting the next mole.
- MOLE_MIN_CYCLES, 12500000, floor on the mole window (used only with the optional feature).

Ports:
- clk, input, 1, 50 MHz clock.
- Reset, input, 1, asynchronous, active-high.
- state, input, 4, FSM state code: Start=0, Game=1, Mole1..Mole4=2..5, GameOver=6; other codes are treated as Start.
- game_start, input, 1, high while FSM is in Start.
- key, input, 4, raw hit buttons, active-high, asynchronous; key[i] hits Mole(i+1).
- control_signal, output, 1, single-cycle pulse to FSM.
- timer_signal, output, 1, level: game time exhausted.
- score, output, 8, hits this game, saturating at 255.
- misses, output, 8, misses this game, saturating at 255.
- time_left, output, 7, seconds remaining.

Behaviour:
- Reset: async clear. control_signal=0, timer_signal=0, score=0, misses=0, time_left=GAME_SECONDS, all counters 0, armed=1. Synchronizers cleared.
- Key path:
  - Each key bit passes through a 2-flop synchronizer, then a rising-edge detector.
  - A press is seen 3 clk after the key edge.
  - Level-held keys produce one event only.
- Start (or game_start=1):
  - Clear score and misses; load time_left=GAME_SECONDS; clear the tick counter.
  - Deassert timer_signal; set armed=1; no pulses.
- Second tick (active only in Game or Mole1..4, and only while timer_signal=0):
  - Tick counter counts 0..TICK_DIV-1; on wrap, time_left decrements.
  - When time_left goes 1->0, timer_signal rises in the same cycle as the decrement.
  - timer_signal holds until Start is seen or Reset.
  - time_left never goes below 0.
- Handshake:
  - Each control_signal pulse lasts exactly 1 cycle and clears armed.
  - armed is set again only when state differs from the state code sampled at the pulse.
  - While armed=0, no pulse is issued and no hit/miss is scored.
  - This absorbs the FSM's 2-cycle registered latency.
- Game state, armed=1:
  - Gap counter counts up to GAP_CYCLES-1, then issues a pulse (mole request) and clears.
  - The gap counter is cleared whenever state is not Game.
- MoleN state, armed=1:
  - Window counter runs 0..window-1.
  - Press on key[N-2] in the same cycle: score+1, pulse.
  - Press on any other key: misses+1, no pulse, the window keeps running.
  - Window expiry: misses+1, pulse.
  - Hit and expiry in the same cycle: hit wins, single pulse.
  - Multiple keys in one cycle: a hit if the correct key is among them, otherwise one miss.
  - The window counter is cleared on entering any Mole state.
- GameOver: all counters frozen; no pulses; score, misses and time_left hold for display.
- timer_signal=1 in Game or Mole: no new mole request. A hit in the same cycle as expiry still scores and pulses.
- Counter limits: score and misses saturate at 255. All counters are sized by $clog2 of their parameter.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined:
  - window starts at MOLE_CYCLES.
  - After every 4th hit, window -= window>>3, floored at MOLE_MIN_CYCLES.
  - window reloads to MOLE_CYCLES in Start.
- Undefined: window is constant MOLE_CYCLES; no extra registers.

Test Plan:
All scenarios use TICK_DIV=10, GAME_SECONDS=3, MOLE_CYCLES=20, GAP_CYCLES=5, with a bench model of the FSM.
- Reset mid-game with score=7: on Reset, all outputs equal reset values immediately, asynchronously; time_left=3.
- Start->Game, no keys: pulse exactly 5 cycles after state=1; no second pulse until state changes.
- state=3 (Mole2), key[1] rises 10 cycles in: score=1 and a 1-cycle pulse occur 3 cycles after the key edge; misses=0.
- state=4 (Mole3), key[0] pressed, then no correct key: misses=1 on the key press; at window end misses=2 and one pulse.
- Correct key event in the same cycle as window expiry: score+1, misses unchanged, exactly one pulse.
- Play 30 cycles in Game/Mole states: time_left goes 3,2,1,0; timer_signal=1 at cycle 30 and held through GameOver; Start clears it and restores time_left=3.
- With MOLE_SPEEDUP_EN, after 4 hits: window=18 (20-2); with MOLE_MIN_CYCLES=15, window never drops below 15.
